// File: rtl/dmu_rx_pkg.sv
// dmu_rx_pkg: shared types and helpers for the SIU->DMU receive capture stage.
//   rx_state_e : assembly FSM states
//   rx_pkt_t   : one assembled packet as held in the packet FIFO
//   PAY_BEATS  : payload beats per data packet
//   par16()    : per-16-bit-lane parity check, returns 1 if any lane is wrong
package dmu_rx_pkg;

   localparam int PAY_BEATS = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GAP      = 3'd1,
      ST_PAY      = 3'd2,
      ST_DROP_GAP = 3'd3,
      ST_DROP_PAY = 3'd4
   } rx_state_e;

   typedef struct packed {
      logic [127:0] hdr;
      logic [511:0] payload;
      logic         has_data;
      logic [4:0]   par_err;
   } rx_pkt_t;

   // parity[i] covers data[16i+15:16i]; odd mode expects the inverted XOR.
   function automatic logic par16(input logic [127:0] data,
                                  input logic [7:0]   parity,
                                  input logic         odd);
      logic [7:0] lane_par;
      for (int i = 0; i < 8; i++) begin
         lane_par[i] = ^data[16*i +: 16];
      end
      return |(lane_par ^ parity ^ {8{odd}});
   endfunction

endpackage

// File: rtl/dmu_rx_pkt_fifo.sv
// dmu_rx_pkt_fifo: synchronous FIFO of rx_pkt_t entries.
//   clk, rst_l        : clock, synchronous active-low reset (flushes pointers)
//   push, push_data   : enqueue; accepted when not full or when popping same cycle
//   pop               : dequeue head (ignored when empty)
//   empty, count      : occupancy status
//   head              : entry at the read pointer (meaningful only when !empty)
module dmu_rx_pkt_fifo
   import dmu_rx_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic                   push,
   input  rx_pkt_t                push_data,
   input  logic                   pop,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output rx_pkt_t                head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rx_pkt_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/dmu_sio_rx_pkt.sv
// dmu_sio_rx_pkt: SIU->DMU receive capture. Samples header and 4 payload beats,
// checks per-lane parity, assembles packets into a FIFO presented on a
// valid/ready interface, and returns one credit per dequeued packet.
//   iol2clk, rst_l              : clock, synchronous active-low reset
//   sio_dmu_hdr_vld/datareq     : header strobe / payload-follows flag
//   sio_dmu_data/parity         : header or payload beat with lane parity
//   rx_pkt_vld/rdy              : FIFO head handshake
//   rx_pkt_hdr/payload/has_data : head packet contents (zero when empty)
//   rx_pkt_par_err              : bit0 header, bits1-4 payload beats 0-3
//   dmu_sio_credit              : one-cycle pulse after each dequeue
//   rx_ovf_err/rx_proto_err     : sticky errors, cleared by err_clr
//
// state        | meaning
// ST_IDLE      | waiting for a header
// ST_GAP       | dead cycle between payload header and beat 0
// ST_PAY       | capturing payload beat beat_q
// ST_DROP_GAP  | as ST_GAP, packet was refused (FIFO full)
// ST_DROP_PAY  | as ST_PAY, beats discarded
module dmu_sio_rx_pkt
   import dmu_rx_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int PARITY_ODD = 0
) (
   input  logic         iol2clk,
   input  logic         rst_l,
   input  logic         sio_dmu_hdr_vld,
   input  logic         sio_dmu_datareq,
   input  logic [127:0] sio_dmu_data,
   input  logic [7:0]   sio_dmu_parity,
   output logic         rx_pkt_vld,
   input  logic         rx_pkt_rdy,
   output logic [127:0] rx_pkt_hdr,
   output logic [511:0] rx_pkt_payload,
   output logic         rx_pkt_has_data,
   output logic [4:0]   rx_pkt_par_err,
   output logic         dmu_sio_credit,
   output logic         rx_ovf_err,
   output logic         rx_proto_err,
   input  logic         err_clr
);

   localparam logic ODD = (PARITY_ODD != 0);
   localparam int   CW  = $clog2(DEPTH) + 1;

   rx_state_e     state_q, state_d;
   logic [1:0]    beat_q, beat_d;
   rx_pkt_t       stage_q, stage_d;
   rx_pkt_t       hdr_pkt, push_data, head, head_vis;
   logic          push, pop, admit, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          credit_q, credit_d;
   logic          ovf_q, ovf_d, ovf_set;
   logic          proto_q, proto_d, proto_set;
   logic          beat_err;

   assign pop      = rx_pkt_vld && rx_pkt_rdy;
   // Room is judged after any same-cycle dequeue. A payload packet reserves
   // its slot here: nothing else can push until it commits.
   assign admit    = (fifo_count < CW'(DEPTH)) || pop;
   assign beat_err = par16(sio_dmu_data, sio_dmu_parity, ODD);

   always_comb begin
      hdr_pkt            = '0;
      hdr_pkt.hdr        = sio_dmu_data;
      hdr_pkt.has_data   = sio_dmu_datareq;
      hdr_pkt.par_err[0] = beat_err;
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      stage_d   = stage_q;
      push      = 1'b0;
      push_data = stage_q;
      ovf_set   = 1'b0;
      proto_set = 1'b0;
      if (sio_dmu_hdr_vld) begin
         // A header in any state restarts assembly; outside IDLE the partial
         // packet is abandoned.
         proto_set = (state_q != ST_IDLE);
         beat_d    = '0;
         if (admit) begin
            if (sio_dmu_datareq) begin
               stage_d = hdr_pkt;
               state_d = ST_GAP;
            end else begin
               push      = 1'b1;
               push_data = hdr_pkt;
               state_d   = ST_IDLE;
            end
         end else begin
            ovf_set = 1'b1;
            state_d = sio_dmu_datareq ? ST_DROP_GAP : ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_GAP: begin
               state_d = ST_PAY;
               beat_d  = '0;
            end
            ST_DROP_GAP: begin
               state_d = ST_DROP_PAY;
               beat_d  = '0;
            end
            ST_PAY: begin
               stage_d.payload[128*beat_q +: 128]       = sio_dmu_data;
               stage_d.par_err[{1'b0, beat_q} + 3'd1]   = beat_err;
               if (beat_q == 2'(PAY_BEATS - 1)) begin
                  push      = 1'b1;
                  push_data = stage_d;
                  state_d   = ST_IDLE;
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
            ST_DROP_PAY: begin
               if (beat_q == 2'(PAY_BEATS - 1)) state_d = ST_IDLE;
               else                             beat_d  = beat_q + 2'd1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A set in the same cycle as err_clr wins.
   assign ovf_d    = ovf_set   | (ovf_q   & ~err_clr);
   assign proto_d  = proto_set | (proto_q & ~err_clr);
   assign credit_d = pop;

   always_ff @(posedge iol2clk) begin
      if (!rst_l) begin
         state_q  <= ST_IDLE;
         beat_q   <= '0;
         stage_q  <= '0;
         credit_q <= 1'b0;
         ovf_q    <= 1'b0;
         proto_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         stage_q  <= stage_d;
         credit_q <= credit_d;
         ovf_q    <= ovf_d;
         proto_q  <= proto_d;
      end
   end

   dmu_rx_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (iol2clk),
      .rst_l     (rst_l),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (head)
   );

   // Stale entries behind the read pointer never leak onto the outputs.
   assign head_vis        = fifo_empty ? '0 : head;
   assign rx_pkt_vld      = !fifo_empty;
   assign rx_pkt_hdr      = head_vis.hdr;
   assign rx_pkt_payload  = head_vis.payload;
   assign rx_pkt_has_data = head_vis.has_data;
   assign rx_pkt_par_err  = head_vis.par_err;
   assign dmu_sio_credit  = credit_q;
   assign rx_ovf_err      = ovf_q;
   assign rx_proto_err    = proto_q;

endmodule

// File: tb/tb_dmu_sio_rx_pkt.sv
module tb_dmu_sio_rx_pkt;

   localparam int DEPTH = 2;

   logic         iol2clk = 1'b0;
   logic         rst_l   = 1'b0;
   logic         hdr_vld = 1'b0;
   logic         datareq = 1'b0;
   logic [127:0] data    = '0;
   logic [7:0]   par     = '0;
   logic         rdy     = 1'b0;
   logic         err_clr = 1'b0;

   logic         e_vld, e_has, e_credit, e_ovf, e_proto;
   logic [127:0] e_hdr;
   logic [511:0] e_pay;
   logic [4:0]   e_perr;
   logic         o_vld, o_has, o_credit, o_ovf, o_proto;
   logic [127:0] o_hdr;
   logic [511:0] o_pay;
   logic [4:0]   o_perr;

   always #5 iol2clk = ~iol2clk;

   dmu_sio_rx_pkt #(.DEPTH(DEPTH), .PARITY_ODD(0)) u_dut_even (
      .iol2clk(iol2clk), .rst_l(rst_l),
      .sio_dmu_hdr_vld(hdr_vld), .sio_dmu_datareq(datareq),
      .sio_dmu_data(data), .sio_dmu_parity(par),
      .rx_pkt_vld(e_vld), .rx_pkt_rdy(rdy), .rx_pkt_hdr(e_hdr),
      .rx_pkt_payload(e_pay), .rx_pkt_has_data(e_has), .rx_pkt_par_err(e_perr),
      .dmu_sio_credit(e_credit), .rx_ovf_err(e_ovf), .rx_proto_err(e_proto),
      .err_clr(err_clr)
   );

   dmu_sio_rx_pkt #(.DEPTH(DEPTH), .PARITY_ODD(1)) u_dut_odd (
      .iol2clk(iol2clk), .rst_l(rst_l),
      .sio_dmu_hdr_vld(hdr_vld), .sio_dmu_datareq(datareq),
      .sio_dmu_data(data), .sio_dmu_parity(par),
      .rx_pkt_vld(o_vld), .rx_pkt_rdy(rdy), .rx_pkt_hdr(o_hdr),
      .rx_pkt_payload(o_pay), .rx_pkt_has_data(o_has), .rx_pkt_par_err(o_perr),
      .dmu_sio_credit(o_credit), .rx_ovf_err(o_ovf), .rx_proto_err(o_proto),
      .err_clr(err_clr)
   );

   typedef struct {
      logic [127:0] hdr;
      logic [511:0] pay;
      logic         has;
      logic [4:0]   perr_e;
      logic [4:0]   perr_o;
   } exp_t;

   exp_t exp_q_e[$];
   exp_t exp_q_o[$];

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state (packet level).
   int   occ     = 0;   // packets in the model FIFO
   int   busy    = 0;   // cycles left in the current payload packet (5 = gap)
   bit   drop    = 0;
   bit   m_ovf   = 0;
   bit   m_proto = 0;
   bit   m_credit = 0;
   exp_t cur;

   task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] even_par(input logic [127:0] d);
      logic [7:0]  p;
      logic [15:0] w;
      for (int i = 0; i < 8; i++) begin
         w    = d[16*i +: 16];
         p[i] = ($countones(w) % 2) == 1;
      end
      return p;
   endfunction

   function automatic logic lane_err(input logic [127:0] d, input logic [7:0] p, input bit odd);
      logic        e;
      logic [15:0] w;
      bit          want;
      e = 1'b0;
      for (int i = 0; i < 8; i++) begin
         w    = d[16*i +: 16];
         want = (($countones(w) % 2) == 1) ^ odd;
         if (p[i] != want) e = 1'b1;
      end
      return e;
   endfunction

   task automatic commit();
      exp_q_e.push_back(cur);
      exp_q_o.push_back(cur);
      occ++;
   endtask

   // Reference model: evaluates the spec rules once per sampling edge.
   initial begin
      int k;
      forever begin
         @(posedge iol2clk);
         if (!rst_l) begin
            occ = 0; busy = 0; drop = 0;
            m_ovf = 0; m_proto = 0; m_credit = 0;
            exp_q_e.delete();
            exp_q_o.delete();
         end else begin
            m_credit = rdy && (occ > 0);
            if (m_credit) occ--;
            if (err_clr) begin
               m_ovf   = 0;
               m_proto = 0;
            end
            if (hdr_vld) begin
               if (busy > 0) m_proto = 1;
               busy       = 0;
               cur.hdr    = data;
               cur.pay    = '0;
               cur.has    = datareq;
               cur.perr_e = {4'b0, lane_err(data, par, 0)};
               cur.perr_o = {4'b0, lane_err(data, par, 1)};
               if (occ < DEPTH) begin
                  if (datareq) begin busy = 5; drop = 0; end
                  else commit();
               end else begin
                  m_ovf = 1;
                  if (datareq) begin busy = 5; drop = 1; end
               end
            end else if (busy > 0) begin
               if (busy <= 4 && !drop) begin
                  k = 4 - busy;
                  cur.pay[128*k +: 128] = data;
                  cur.perr_e[k+1]       = lane_err(data, par, 0);
                  cur.perr_o[k+1]       = lane_err(data, par, 1);
               end
               busy--;
               if (busy == 0 && !drop) commit();
            end
         end
      end
   end

   // Monitor: compares status every cycle and pops the scoreboard on handshakes.
   initial begin
      exp_t x;
      forever begin
         @(negedge iol2clk);
         chk("vld_even",    e_vld,    occ > 0);
         chk("vld_odd",     o_vld,    occ > 0);
         chk("credit_even", e_credit, m_credit);
         chk("credit_odd",  o_credit, m_credit);
         chk("ovf_even",    e_ovf,    m_ovf);
         chk("ovf_odd",     o_ovf,    m_ovf);
         chk("proto_even",  e_proto,  m_proto);
         chk("proto_odd",   o_proto,  m_proto);
         if (rst_l && rdy && e_vld) begin
            if (exp_q_e.size() == 0) begin
               chk("unexpected_pkt_even", 1'b1, 1'b0);
            end else begin
               x = exp_q_e.pop_front();
               chk("hdr_even",     e_hdr,  x.hdr);
               chk("payload_even", e_pay,  x.pay);
               chk("has_data_even", e_has, x.has);
               chk("par_err_even", e_perr, x.perr_e);
            end
         end
         if (rst_l && rdy && o_vld) begin
            if (exp_q_o.size() == 0) begin
               chk("unexpected_pkt_odd", 1'b1, 1'b0);
            end else begin
               x = exp_q_o.pop_front();
               chk("hdr_odd",      o_hdr,  x.hdr);
               chk("payload_odd",  o_pay,  x.pay);
               chk("has_data_odd", o_has,  x.has);
               chk("par_err_odd",  o_perr, x.perr_o);
            end
         end
      end
   end

   task automatic drive(input bit h, input bit dr, input logic [127:0] d,
                        input logic [7:0] p, input bit r, input bit c);
      @(posedge iol2clk);
      #1;
      hdr_vld = h; datareq = dr; data = d; par = p; rdy = r; err_clr = c;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle(input int n, input bit r);
      logic [127:0] d;
      for (int i = 0; i < n; i++) begin
         d = rnd128();
         drive(0, 1'($urandom % 2), d, even_par(d), r, 0);
      end
   endtask

   task automatic hdr_only(input logic [127:0] d, input bit r);
      drive(1, 0, d, even_par(d), r, 0);
   endtask

   task automatic pay_pkt(input logic [127:0] h, input logic [7:0] b2_flip);
      logic [127:0] b;
      drive(1, 1, h, even_par(h), 1, 0);
      idle(1, 1);
      for (int k = 0; k < 4; k++) begin
         b = {16{8'(8'hA0 + k)}};
         drive(0, 0, b, even_par(b) ^ ((k == 2) ? b2_flip : 8'h00), 1, 0);
      end
   endtask

   task automatic do_reset();
      @(posedge iol2clk);
      #1;
      rst_l = 0; hdr_vld = 0; datareq = 0; err_clr = 0;
      @(posedge iol2clk);
      @(negedge iol2clk);
      chk("rst_vld",     {e_vld, o_vld}, 2'b00);
      chk("rst_hdr",     e_hdr | o_hdr, '0);
      chk("rst_payload", e_pay | o_pay, '0);
      chk("rst_has",     {e_has, o_has}, 2'b00);
      chk("rst_par_err", {e_perr, o_perr}, 10'd0);
      chk("rst_credit",  {e_credit, o_credit}, 2'b00);
      chk("rst_errs",    {e_ovf, e_proto, o_ovf, o_proto}, 4'd0);
      #1;
      rst_l = 1;
   endtask

   initial begin
      logic [127:0] d;
      logic [7:0]   p;
      do_reset();

      // Header-only packet, consumer ready.
      hdr_only({8{16'h1234}}, 1);
      idle(3, 1);

      // Payload packet, then one with a bad parity lane on beat 2.
      pay_pkt({8{16'h5A5A}}, 8'h00);
      idle(3, 1);
      pay_pkt({8{16'h0F0F}}, 8'h08);
      idle(3, 1);

      // Overflow: consumer stalled, three headers; fourth arrives with a pop.
      hdr_only(rnd128(), 0);
      hdr_only(rnd128(), 0);
      hdr_only(rnd128(), 0);
      hdr_only(rnd128(), 1);
      idle(4, 1);
      drive(0, 0, '0, '0, 1, 1);
      idle(2, 1);

      // Protocol abort: header-only at T+3 after a payload header.
      drive(1, 1, {8{16'hBEEF}}, even_par({8{16'hBEEF}}), 1, 0);
      idle(2, 1);
      hdr_only({8{16'hCAFE}}, 1);
      idle(4, 1);
      drive(0, 0, '0, '0, 1, 1);
      idle(2, 1);

      // Reset in the middle of a payload packet, then a normal header.
      drive(1, 1, rnd128(), 8'h00, 1, 0);
      idle(2, 1);
      do_reset();
      hdr_only({8{16'h7777}}, 1);
      idle(3, 1);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(999) < 3) begin
            do_reset();
         end else begin
            d = rnd128();
            p = even_par(d);
            if ($urandom_range(9) == 0) p = p ^ (8'h01 << $urandom_range(7));
            drive($urandom_range(99) < 20, 1'($urandom % 2), d, p,
                  $urandom_range(9) < 7, $urandom_range(99) < 5);
         end
      end

      idle(20, 1);
      chk("drain_even", exp_q_e.size(), 0);
      chk("drain_odd",  exp_q_o.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
